// File: rtl/rv_mem_arb.sv
// rtl/rv_mem_arb.sv - two-port fetch/data arbiter onto a single-cycle shared memory port
//
// Purpose: arbitrates an instruction-fetch port and a data port onto one
// memory port. Data wins by default; a fetch that has been denied
// STARVE_MAX cycles in a row is forced through. Reads return one cycle
// after the grant and are steered back to the requester that owned the slot.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   if_req/if_addr                fetch request (read only)
//   if_gnt/if_rvalid/if_rdata     fetch grant and read response
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata   data request
//   dm_gnt/dm_rvalid/dm_rdata     data grant and read response
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  shared memory request
//   mem_rdata                     memory read data, one cycle after a read
//   conflict_cnt                  saturating count of both-requesting cycles

module rv_mem_arb #(
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [31:0]      if_rdata,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [3:0]       dm_be,
  input  logic [31:0]      dm_addr,
  input  logic [31:0]      dm_wdata,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  output logic [31:0]      dm_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  owner_t        owner, owner_nxt;
  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == SW'(STARVE_MAX));

  // Grants are combinational and held off entirely while reset is asserted.
  assign if_gnt = rst_n && if_req && (!dm_req || starved);
  assign dm_gnt = rst_n && dm_req && !if_gnt;

  always_comb begin
    mem_req   = if_gnt || dm_gnt;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (if_gnt) begin
      mem_be   = 4'hF;
      mem_addr = if_addr;
    end else if (dm_gnt) begin
      mem_we    = dm_we;
      mem_be    = dm_be;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_req && !if_gnt) begin
      if (!starved) starve_cnt <= starve_cnt + SW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (if_req && dm_req && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  // Owner FSM: remembers who gets next cycle's read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) owner <= OWN_NONE;
    else        owner <= owner_nxt;
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    if (if_gnt)                owner_nxt = OWN_IF;
    else if (dm_gnt && !dm_we) owner_nxt = OWN_DM;
  end

  always_comb begin
    if_rvalid = (owner == OWN_IF);
    dm_rvalid = (owner == OWN_DM);
    if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    dm_rdata  = dm_rvalid ? mem_rdata : 32'h0;
  end

endmodule

// File: doc/rv_mem_arb.md
RV_MEM_ARB -- requirements
Module: rv_mem_arb

Interface
REQ-001 Parameter STARVE_MAX, default 3: consecutive denied fetch cycles before fetch is forced to win.
REQ-002 Parameter CNT_W, default 16: width of the conflict statistics counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  fetch read request.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_gnt  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid  out  1  fetch read data valid.
REQ-009 if_rdata  out  32  fetch read data.
REQ-010 dm_req  in  1  data request, read or write.
REQ-011 dm_we  in  1  data write enable.
REQ-012 dm_be  in  4  data byte enables.
REQ-013 dm_addr  in  32  data byte address.
REQ-014 dm_wdata  in  32  data write data.
REQ-015 dm_gnt  out  1  data request accepted this cycle.
REQ-016 dm_rvalid  out  1  data read data valid.
REQ-017 dm_rdata  out  32  data read data.
REQ-018 mem_req, mem_we, mem_be[4], mem_addr[32], mem_wdata[32]  out  shared memory port.
REQ-019 mem_rdata  in  32  shared memory read data; valid exactly 1 cycle after a read is presented.
REQ-020 conflict_cnt  out  CNT_W  number of cycles in which both if_req and dm_req were high.

Function
REQ-021 The grant SHALL be combinational in the same cycle: at most one of if_gnt and dm_gnt is high, and a grant is high only when its request is high.
REQ-022 Priority SHALL be data over fetch, unless starve_cnt == STARVE_MAX, in which case fetch wins.
REQ-023 The mem_* outputs SHALL mirror the granted requester: mem_we = dm_we and mem_be = dm_be on a data grant; mem_we = 0 and mem_be = 4'hF on a fetch grant; all mem_* outputs are 0 when there is no grant.
REQ-024 starve_cnt SHALL increment by 1 on each cycle with if_req && !if_gnt, saturating at STARVE_MAX, and SHALL clear to 0 on any cycle with if_gnt or !if_req.
REQ-025 Owner register states SHALL be NONE, IF, DM; the next state is IF on a fetch grant, DM on a data read grant (dm_we = 0), and NONE otherwise, including on a data write.
REQ-026 Read latency SHALL be 1 cycle: if_rvalid = (owner == IF) and dm_rvalid = (owner == DM).
REQ-027 if_rdata and dm_rdata SHALL equal mem_rdata when their rvalid is high and 0 otherwise.
REQ-028 Writes SHALL produce no rvalid.
REQ-029 Back-to-back grants SHALL be allowed every cycle; a new grant in the same cycle as a response is legal.
REQ-030 Requesters SHALL hold their request and payload stable until granted; the arbiter does not latch requests.
REQ-031 conflict_cnt SHALL increment on each cycle with if_req && dm_req, saturating at all-ones.
REQ-032 A continuous data request stream SHALL still grant fetch at least once every STARVE_MAX+1 cycles.

Reset
REQ-033 Asserting rst_n low SHALL immediately clear: owner = NONE, starve_cnt = 0, conflict_cnt = 0, if_rvalid = dm_rvalid = 0.
REQ-034 Rdata outputs SHALL read 0 while rst_n is low.
REQ-035 A read response pending at reset assertion SHALL be dropped and no rvalid emitted for it.
REQ-036 Grant logic SHALL be inactive while rst_n is low: all gnt outputs and mem_req are 0.
REQ-037 Normal operation SHALL resume on the first rising edge after rst_n deasserts.

Verification
REQ-038 Fetch alone: if_req = 1, if_addr = 0x100 -> if_gnt = 1 and mem_addr = 0x100 in the same cycle; next cycle if_rvalid = 1 and if_rdata = mem_rdata.
REQ-039 Data write: dm_req = 1, dm_we = 1, dm_be = 4'b0011, dm_wdata = 0xDEADBEEF -> mem_we = 1, mem_be = 4'b0011; no rvalid on the next cycle.
REQ-040 Starvation: both requests held high continuously -> grant sequence DM, DM, DM, IF, repeating; conflict_cnt = 8 after 8 cycles.
REQ-041 Conflict counter saturation with CNT_W = 4: 20 conflict cycles -> conflict_cnt = 15.
REQ-042 Reset mid-read: data read granted, rst_n pulled low before the next edge -> dm_rvalid stays 0 and owner = NONE after release.
REQ-043 Alternating responses: fetch grant in cycle N, data read grant in N+1 -> if_rvalid in N+1, dm_rvalid in N+2, each never asserted together with the other for the same cycle.
